// File: rtl/mem_fill_responder_if.sv
// Request/response bundle between the cache fill FSM (master) and the memory responder (slave).
interface mem_fill_responder_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [ADDR_W-1:0] ret_addr;
  logic              fill_done;
  logic              wr_ack;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, ret_addr, fill_done, wr_ack
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, ret_addr, fill_done, wr_ack
  );
endinterface

// File: rtl/mem_fill_responder.sv
// Fixed-latency pipelined memory responder with in-order 8-beat fill tracking.
// Optional RESP_WRITE_ACK_EN: writes ride the pipeline and return a wr_ack pulse.
module mem_fill_responder #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned WORDS_LOG2 = 15
) (
  input logic                  clk,
  input logic                  rst,
  mem_fill_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << WORDS_LOG2;
  localparam int unsigned LAST  = LATENCY - 1;

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("mem_fill_responder: LATENCY must be within 1..8");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic                  rd_req;
  logic                  wr_req;
  logic [WORDS_LOG2-1:0] idx;

  logic [LATENCY-1:0]             vld_q;
  logic [LATENCY-1:0][ADDR_W-1:0] addr_q;
  logic [LATENCY-1:0][DATA_W-1:0] data_q;
  logic                           vld0_d;
  logic [ADDR_W-1:0]              addr0_d;
  logic [DATA_W-1:0]              data0_d;

  logic [2:0] cnt_q, cnt_d;
  logic [2:0] off;

  assign rd_req = bus.enable & ~bus.wr;
  assign wr_req = bus.enable & bus.wr;
  assign idx    = bus.addr[WORDS_LOG2:1];

  // Bubbles and write slots load zeros so the last stage is already output-clean.
  always_comb begin
    vld0_d  = rd_req;
    addr0_d = '0;
    data0_d = '0;
    if (rd_req) begin
      addr0_d = bus.addr & ~ADDR_W'(1);
      data0_d = mem[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
        data_q[i] <= data_q[i-1];
      end
      vld_q[0]  <= vld0_d;
      addr_q[0] <= addr0_d;
      data_q[0] <= data0_d;
    end
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_req) begin
      mem[idx] <= bus.data_in;
    end
  end

  assign off = addr_q[LAST][3:1];

  always_comb begin
    cnt_d = cnt_q;
    if (vld_q[LAST]) begin
      if (off == cnt_q) begin
        cnt_d = cnt_q + 3'd1;
      end else if (off == 3'd0) begin
        cnt_d = 3'd1;
      end else begin
        cnt_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.data_valid = vld_q[LAST];
  assign bus.data_out   = data_q[LAST];
  assign bus.ret_addr   = addr_q[LAST];
  assign bus.fill_done  = vld_q[LAST] & (off == 3'd7) & (cnt_q == 3'd7);

`ifdef RESP_WRITE_ACK_EN
  logic [LATENCY-1:0] ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= '0;
    end else begin
      for (int i = 1; i < int'(LATENCY); i++) begin
        ack_q[i] <= ack_q[i-1];
      end
      ack_q[0] <= wr_req;
    end
  end

  assign bus.wr_ack = ack_q[LAST];
`else
  assign bus.wr_ack = 1'b0;
`endif

endmodule
